// File: rtl/arm_reg_bank.sv
// Multi-port register bank: DEPTH x WIDTH storage, two combinational read ports,
// one write port. The top entry is the program counter with its own increment path.
module arm_reg_bank #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter int AW             = $clog2(DEPTH),
  parameter int PC_STEP        = 4,
  parameter int PC_READ_OFFSET = 8,
  parameter int BYPASS         = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_qn
);

  localparam logic [AW-1:0]    PC_IDX  = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] RD_OFFS = WIDTH'(PC_READ_OFFSET);
  localparam bit               BYP_EN  = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] pc_rd;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (pc_inc) begin
      regs_d[DEPTH-1] = regs_q[DEPTH-1] + STEP;
    end
    // A write to the PC index lands after the increment, so it wins the collision.
    if (we) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign pc_rd = regs_q[DEPTH-1] + RD_OFFS;

  // The PC is never bypassed: a same-cycle PC write shows up next cycle.
  always_comb begin
    rd_a = regs_q[ra_a];
    if (ra_a == PC_IDX) begin
      rd_a = pc_rd;
    end else if (BYP_EN && we && (wa == ra_a)) begin
      rd_a = wd;
    end
  end

  always_comb begin
    rd_b = regs_q[ra_b];
    if (ra_b == PC_IDX) begin
      rd_b = pc_rd;
    end else if (BYP_EN && we && (wa == ra_b)) begin
      rd_b = wd;
    end
  end

  assign pc_q  = regs_q[DEPTH-1];
  assign pc_qn = ~regs_q[DEPTH-1];

endmodule

// File: doc/arm_reg_bank.md
# arm_reg_bank

Parametrised multi-port register bank that replaces the individual 32-bit enable/clear registers in the datapath with one storage block. It holds DEPTH general registers of WIDTH bits. The top entry serves as the program counter, with its own auto-increment path and read offset. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- WIDTH, 32, data width of every register
- DEPTH, 16, number of registers; power of two, at least 2; index DEPTH-1 is the PC
- AW, $clog2(DEPTH), address width (derived, not overridden)
- PC_STEP, 4, amount added to the PC on pc_inc
- PC_READ_OFFSET, 8, value added to the stored PC when the PC is read through rd_a/rd_b
- BYPASS, 1, 1 forwards same-cycle write data to the read ports; 0 disables forwarding

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  synchronous active-high clear
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra_a  in  AW  read address, port A
- ra_b  in  AW  read address, port B
- rd_a  out  WIDTH  read data, port A (combinational)
- rd_b  out  WIDTH  read data, port B (combinational)
- pc_inc  in  1  advance PC by PC_STEP
- pc_q  out  WIDTH  stored PC (registered, no offset)
- pc_qn  out  WIDTH  bitwise complement of pc_q

## Operation
- Storage: array of DEPTH x WIDTH flops. Entries 0..DEPTH-2 are general registers; entry DEPTH-1 is the PC.
- Clear: clr=1 at a rising edge sets every entry to 0. clr overrides we and pc_inc in the same cycle.
- General write: we=1 and wa != DEPTH-1 writes wd to entry wa at the edge.
- PC update priority, when clr=0:
  - we=1 with wa=DEPTH-1 loads wd. This holds even if pc_inc=1.
  - Otherwise pc_inc=1 loads PC + PC_STEP, modulo 2^WIDTH (wraps silently).
  - Otherwise the PC holds.
- Read of a general register (ra != DEPTH-1):
  - If BYPASS=1, we=1 and wa==ra, the port returns wd.
  - Otherwise the port returns the stored entry.
- Read of the PC (ra == DEPTH-1): the port returns stored PC + PC_READ_OFFSET, modulo 2^WIDTH. No bypass applies to the PC, so a same-cycle PC write is visible on the next cycle.
- Ports A and B are independent. Both may address the same register.
- Any write to address DEPTH-1 goes to the PC. No write can corrupt another entry.
- Write-enable gating: with we=0 and pc_inc=0, no entry changes, whatever wa/wd are doing.

## Timing
- Reset values after a clr edge:
  - every entry 0
  - pc_q = 0
  - pc_qn = all ones
  - rd_a/rd_b = 0 for a general address; PC_READ_OFFSET for address DEPTH-1
- Write latency: 1 edge. The stored value is visible on the unbypassed read path and on pc_q in the cycle after the edge.
- Bypass latency: 0 cycles (combinational from wd/we/wa to rd_*), general registers only.
- pc_inc latency: 1 edge. Consecutive pc_inc cycles add PC_STEP per edge.
- clr asserted mid-operation: a pending write or increment in that cycle is discarded. The next cycle starts from all-zero state.
- rd_a, rd_b and pc_qn have no registered stage beyond the storage flops.

## Test plan
- Clear: preload r3=0xDEADBEEF and PC=0x100, then pulse clr with we=1, wa=3, wd=0x1234. Required after the edge: r3=0, pc_q=0, pc_qn=0xFFFFFFFF, rd_a(ra=15)=0x8.
- Write/read and bypass: write r5=0xA5A5A5A5, then read on both ports next cycle; both return 0xA5A5A5A5. In the same cycle as we=1, wa=7, wd=0x55, rd_a(ra=7) shows 0x55 with BYPASS=1, and the old value with BYPASS=0.
- PC increment and wrap: load PC=0xFFFFFFF8, then hold pc_inc=1 for 3 edges. pc_q must read 0xFFFFFFFC, 0x0, 0x4; rd_b(ra=15) reads 0x4, 0x8, 0xC.
- PC write/increment collision: pc_q=0x200, and in one cycle we=1, wa=15, wd=0x1000 with pc_inc=1. Required: pc_q=0x1000 next cycle, and rd_a(ra=15)=0x1008 during the write cycle it still shows 0x208.
- Enable gating: we=0, wa=2, wd=0xFFFFFFFF for 5 edges. r2 keeps its prior value 0x0000_0011 and the PC is unchanged.
- Parameter sweep: WIDTH=16, DEPTH=8, PC_STEP=2. Writes to wa=7 land in the PC, and an increment from 0xFFFE wraps to 0x0000.
